// File: rtl/l1_l2_write_buffer.sv
// rtl/l1_l2_write_buffer.sv - L1-to-L2 block write buffer with read forwarding.
// Optional write coalescing into non-draining entries: define WB_COALESCE_EN.
module l1_l2_write_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        u_request,
   input  logic        u_we,
   input  logic [5:0]  u_addr,
   input  logic [31:0] u_din,
   output logic        u_ready,
   output logic [31:0] u_dout,
   output logic        d_request,
   output logic        d_we,
   output logic [5:0]  d_addr,
   output logic [31:0] d_din,
   input  logic        d_ready,
   input  logic [31:0] d_dout
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {D_IDLE, D_DRAIN, D_READ} d_state_t;
   typedef enum logic {U_IDLE, U_MISS} u_state_t;

   d_state_t d_state;
   u_state_t u_state;

   logic [5:0]       mem_addr [DEPTH];
   logic [31:0]      mem_data [DEPTH];
   logic [DEPTH-1:0] mem_valid;
   logic [PW-1:0]    head, tail, scan_idx;
   logic [CW-1:0]    count;

   logic        new_req, full, pop, push, wr_accept, wr_coalesce, miss_now;
   logic        rd_hit;
   logic [31:0] rd_data;
`ifdef WB_COALESCE_EN
   logic          co_hit;
   logic [PW-1:0] co_idx;
`endif

   // L1 holds its request through the u_ready cycle, so that cycle is never re-sampled.
   assign new_req = (u_state == U_IDLE) && u_request && !u_ready;
   assign full    = (count == CW'(DEPTH));
   assign pop     = (d_state == D_DRAIN) && d_ready;

   // Scan oldest to youngest so the last match found is the youngest copy.
   always_comb begin
      rd_hit   = 1'b0;
      rd_data  = '0;
      scan_idx = head;
`ifdef WB_COALESCE_EN
      co_hit   = 1'b0;
      co_idx   = head;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = head + PW'(i);
         if (mem_valid[scan_idx] && (mem_addr[scan_idx] == u_addr)) begin
            rd_hit  = 1'b1;
            rd_data = mem_data[scan_idx];
`ifdef WB_COALESCE_EN
            if ((i != 0) || (d_state != D_DRAIN)) begin
               co_hit = 1'b1;
               co_idx = scan_idx;
            end
`endif
         end
      end
   end

`ifdef WB_COALESCE_EN
   assign wr_coalesce = co_hit;
`else
   assign wr_coalesce = 1'b0;
`endif

   // A stalled write at full may complete on the same edge that frees the head.
   assign wr_accept = new_req && u_we && (wr_coalesce || !full || pop);
   assign push      = wr_accept && !wr_coalesce;
   assign miss_now  = new_req && !u_we && !rd_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         mem_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_addr[i] <= '0;
            mem_data[i] <= '0;
         end
         u_state   <= U_IDLE;
         u_ready   <= 1'b0;
         u_dout    <= '0;
      end else begin
         u_ready <= 1'b0;
         if (pop) begin
            mem_valid[head] <= 1'b0;
            head            <= head + PW'(1);
         end
         if (push) begin
            mem_addr[tail]  <= u_addr;
            mem_data[tail]  <= u_din;
            mem_valid[tail] <= 1'b1;
            tail            <= tail + PW'(1);
         end
`ifdef WB_COALESCE_EN
         if (wr_accept && wr_coalesce) begin
            mem_data[co_idx] <= u_din;
         end
`endif
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
         case (u_state)
            U_IDLE: begin
               if (wr_accept) begin
                  u_ready <= 1'b1;
               end else if (new_req && !u_we) begin
                  if (rd_hit) begin
                     u_dout  <= rd_data;
                     u_ready <= 1'b1;
                  end else begin
                     u_state <= U_MISS;
                  end
               end
            end
            U_MISS: begin
               if ((d_state == D_READ) && d_ready) begin
                  u_dout  <= d_dout;
                  u_ready <= 1'b1;
                  u_state <= U_IDLE;
               end
            end
            default: u_state <= U_IDLE;
         endcase
      end
   end

   // Downstream port: a pending read miss always wins over draining.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_state   <= D_IDLE;
         d_request <= 1'b0;
         d_we      <= 1'b0;
         d_addr    <= '0;
         d_din     <= '0;
      end else begin
         case (d_state)
            D_IDLE: begin
               if (miss_now || (u_state == U_MISS)) begin
                  d_state   <= D_READ;
                  d_request <= 1'b1;
                  d_we      <= 1'b0;
                  d_addr    <= u_addr;
                  d_din     <= '0;
               end else if (count != '0) begin
                  d_state   <= D_DRAIN;
                  d_request <= 1'b1;
                  d_we      <= 1'b1;
                  d_addr    <= mem_addr[head];
                  d_din     <= mem_data[head];
               end
            end
            D_DRAIN: begin
               if (d_ready) begin
                  d_state   <= D_IDLE;
                  d_request <= 1'b0;
                  d_we      <= 1'b0;
               end
            end
            D_READ: begin
               if (d_ready) begin
                  d_state   <= D_IDLE;
                  d_request <= 1'b0;
               end
            end
            default: d_state <= D_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_l1_l2_write_buffer.sv
// tb/tb_l1_l2_write_buffer.sv - directed self-checking bench for l1_l2_write_buffer.
`timescale 1ns/1ps
module tb_l1_l2_write_buffer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        u_request, u_we, u_ready, d_request, d_we, d_ready;
   logic [5:0]  u_addr, d_addr;
   logic [31:0] u_din, u_dout, d_din, d_dout;

   int n_checks = 0;
   int n_fail   = 0;

   logic        l2_en = 1'b0;
   int          l2_credits = 0;
   int          l2_used = 0;
   logic [38:0] l2_log [$];
   time         t_pop = 0;

   int          cyc;
   logic [31:0] dout;
   time         t_edge;
   int          n;
   logic        seen;
   int          exp_cnt;
   logic [31:0] exp_d1;

   always #5 clk = ~clk;

   l1_l2_write_buffer #(.DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .u_request(u_request), .u_we(u_we), .u_addr(u_addr), .u_din(u_din),
      .u_ready(u_ready), .u_dout(u_dout),
      .d_request(d_request), .d_we(d_we), .d_addr(d_addr), .d_din(d_din),
      .d_ready(d_ready), .d_dout(d_dout)
   );

   function automatic logic [31:0] l2_rd(input logic [5:0] a);
      return 32'hC0DE_0000 | {26'h0, a};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // L2 model: responds one cycle after a request when enabled or granted a credit.
   always @(negedge clk) begin
      if (!rst_n) begin
         d_ready = 1'b0;
      end else if (d_ready) begin
         d_ready = 1'b0;
      end else if (d_request && (l2_en || (l2_used < l2_credits))) begin
         d_ready = 1'b1;
         d_dout  = l2_rd(d_addr);
         if (!l2_en) l2_used++;
      end
   end

   always @(posedge clk) begin
      if (rst_n && d_ready && d_request) begin
         l2_log.push_back({d_we, d_addr, d_din});
         t_pop = $time;
      end
   end

   task automatic l1_req(input logic we, input logic [5:0] addr, input logic [31:0] din,
                         input int max_cyc, output int c, output logic [31:0] d, output time te);
      logic done;
      @(negedge clk);
      u_request = 1'b1; u_we = we; u_addr = addr; u_din = din;
      c = 0; d = '0; te = 0; done = 1'b0;
      while (!done && c < max_cyc) begin
         @(posedge clk);
         #1;
         c++;
         if (u_ready) begin
            d = u_dout; te = $time - 1; done = 1'b1;
         end
      end
      if (!done) c = 999;
      @(negedge clk);
      u_request = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (k < 200 && !(dut.count == '0 && !d_request)) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_idle"}, 32'(k < 200), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; u_request = 1'b0; u_we = 1'b0; u_addr = '0; u_din = '0;
      d_ready = 1'b0; d_dout = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_u_ready", 32'(u_ready), 0);
      check("rst_u_dout", u_dout, 0);
      check("rst_d_request", 32'(d_request), 0);
      check("rst_d_we", 32'(d_we), 0);
      check("rst_d_addr", 32'(d_addr), 0);
      check("rst_d_din", d_din, 0);
      check("rst_count", 32'(dut.count), 0);

      // Reset while a drain is outstanding.
      l1_req(1'b1, 6'h20, 32'h55, 5, cyc, dout, t_edge);
      check("mid_wr_lat", 32'(cyc), 1);
      n = 0;
      while (n < 10 && !d_request) begin @(negedge clk); n++; end
      check("mid_d_request_up", 32'(d_request), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_d_request", 32'(d_request), 0);
      check("mid_rst_d_we", 32'(d_we), 0);
      check("mid_rst_d_din", d_din, 0);
      check("mid_rst_count", 32'(dut.count), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin @(negedge clk); if (d_request) seen = 1'b1; end
      check("mid_no_d_request", 32'(seen), 0);
      l2_log.delete();

      // Fill with L2 stalled, then a fifth write that completes on the pop edge.
      for (int i = 1; i <= 4; i++) begin
         l1_req(1'b1, 6'(i), 32'hA0 + 32'(i), 5, cyc, dout, t_edge);
         check($sformatf("fill_lat_%0d", i), 32'(cyc), 1);
      end
      check("fill_count", 32'(dut.count), 4);
      check("fill_tail_wrap", 32'(dut.tail), 0);
      fork
         l1_req(1'b1, 6'h05, 32'hA5, 40, cyc, dout, t_edge);
         begin
            repeat (4) @(negedge clk);
            check("full_u_ready_low", 32'(u_ready), 0);
            check("full_d_addr", 32'(d_addr), 32'h01);
            check("full_d_din", d_din, 32'hA1);
            check("full_d_we", 32'(d_we), 1);
            l2_credits++;
         end
      join
      check("full_stalled", 32'(cyc > 1 && cyc < 999), 1);
      check("full_same_edge", 32'(t_edge), 32'(t_pop));
      check("full_count_kept", 32'(dut.count), 4);
      check("full_tail", 32'(dut.tail), 1);
      l2_en = 1'b1;
      wait_idle("full");
      check("full_log_size", 32'(l2_log.size()), 5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("full_drain_%0d", i), 32'(l2_log[i]),
               32'({1'b1, 6'(i + 1), 32'hA1 + 32'(i)}));
      end
      l2_log.delete();

      // Read hit on a buffered, still-draining block.
      l2_en = 1'b0;
      l1_req(1'b1, 6'h10, 32'hDEADBEEF, 5, cyc, dout, t_edge);
      l1_req(1'b0, 6'h10, 32'h0, 5, cyc, dout, t_edge);
      check("hit_lat", 32'(cyc), 1);
      check("hit_data", dout, 32'hDEADBEEF);
      check("hit_no_l2_read", 32'(d_we), 1);
      l2_en = 1'b1;
      wait_idle("hit");
      check("hit_log_size", 32'(l2_log.size()), 1);
      check("hit_log_we", 32'(l2_log[0][38]), 1);
      l2_log.delete();

      // Read miss queued behind a drain takes priority over the next drain.
      l2_en = 1'b0;
      l1_req(1'b1, 6'h01, 32'h11, 5, cyc, dout, t_edge);
      l1_req(1'b1, 6'h02, 32'h22, 5, cyc, dout, t_edge);
      fork
         l1_req(1'b0, 6'h3F, 32'h0, 60, cyc, dout, t_edge);
         begin
            repeat (3) @(negedge clk);
            check("miss_wait_drain_we", 32'(d_we), 1);
            check("miss_wait_drain_addr", 32'(d_addr), 32'h01);
            l2_credits++;
            n = 0;
            while (n < 20 && !(d_request && !d_we)) begin @(negedge clk); n++; end
            check("miss_rd_issued", 32'(d_request && !d_we), 1);
            check("miss_rd_addr", 32'(d_addr), 32'h3F);
            l2_credits++;
         end
      join
      check("miss_done", 32'(cyc < 999), 1);
      check("miss_data", dout, l2_rd(6'h3F));
      check("miss_count", 32'(dut.count), 1);
      l2_en = 1'b1;
      wait_idle("miss");
      check("miss_log_size", 32'(l2_log.size()), 3);
      check("miss_order_0", 32'(l2_log[0][38:32]), 32'({1'b1, 6'h01}));
      check("miss_order_1", 32'(l2_log[1][38:32]), 32'({1'b0, 6'h3F}));
      check("miss_order_2", 32'(l2_log[2]), 32'({1'b1, 6'h02, 32'h22}));
      l2_log.delete();

      // Duplicate addresses behind a draining filler entry.
`ifdef WB_COALESCE_EN
      exp_cnt = 2; exp_d1 = 32'h2;
`else
      exp_cnt = 3; exp_d1 = 32'h1;
`endif
      l2_en = 1'b0;
      l1_req(1'b1, 6'h30, 32'h33, 5, cyc, dout, t_edge);
      l1_req(1'b1, 6'h08, 32'h1, 5, cyc, dout, t_edge);
      l1_req(1'b1, 6'h08, 32'h2, 5, cyc, dout, t_edge);
      check("dup_wr_lat", 32'(cyc), 1);
      check("dup_count", 32'(dut.count), 32'(exp_cnt));
      l1_req(1'b0, 6'h08, 32'h0, 5, cyc, dout, t_edge);
      check("dup_youngest", dout, 32'h2);
      l2_en = 1'b1;
      wait_idle("dup");
      check("dup_log_size", 32'(l2_log.size()), 32'(exp_cnt));
      check("dup_drain_0", 32'(l2_log[0]), 32'({1'b1, 6'h30, 32'h33}));
      check("dup_drain_1", 32'(l2_log[1]), 32'({1'b1, 6'h08, exp_d1}));
      check("dup_drain_last", l2_log[l2_log.size() - 1][31:0], 32'h2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1);
   end
endmodule
